alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
Initiator side of the 8-bit ALU interface. Accepts queued ALU commands over a valid/ready handshake and drives the ALU's a/b/sel inputs from registers. Captures the ALU's combinational out/cout one cycle later, keeps a result accumulator, and returns each result over a valid/ready response channel. Sits between a control master (e.g. a test sequencer or small CPU) and the combinational ALU.

Parameters:
WIDTH, 8, operand/result width; fixed at 8 to match the ALU.
DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command offered.
cmd_ready  output  1  command FIFO not full.
cmd_op  input  4  ALU opcode (0000 add … 1111 mod).
cmd_a  input  8  operand A; ignored when cmd_use_acc=1.
cmd_b  input  8  operand B.
cmd_use_acc  input  1  use accumulator as operand A.
alu_a  output  8  registered operand A to ALU.
alu_b  output  8  registered operand B to ALU.
alu_sel  output  4  registered opcode to ALU.
alu_out  input  8  ALU result (combinational from alu_a/b/sel).
alu_cout  input  1  ALU carry (carry of a+b, independent of sel).
rsp_valid  output  1  response available.
rsp_ready  input  1  response consumed.
rsp_data  output  8  result.
rsp_cout  output  1  carry; valid for add only, else 0.
rsp_err  output  1  divide/modulo by zero.
rsp_op  output  4  opcode of this response.
acc_out  output  8  current accumulator.
busy  output  1  FIFO non-empty or state != IDLE.

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, queued commands discarded; state IDLE. alu_a/alu_b/alu_sel=0, rsp_valid/rsp_data/rsp_cout/rsp_err/rsp_op=0, acc_out=0, busy=0, cmd_ready=1. Reset mid-operation drops in-flight results; no response is produced.
- Command push: on an edge with cmd_valid && cmd_ready, {op,a,b,use_acc} is written to the FIFO. cmd_ready = !full. A pop in the same cycle does not permit a push while full.
- FSM states are IDLE, EXEC and RESP.
  - IDLE: if the FIFO is non-empty, pop the head and load alu_sel=op, alu_b=b, alu_a = use_acc ? acc : a. Go to EXEC.
  - EXEC (ALU settles): capture into rsp_data, rsp_cout, rsp_err and rsp_op; set rsp_valid=1; update acc. Go to RESP.
  - RESP: hold all rsp_* stable while rsp_ready=0. On rsp_valid && rsp_ready, clear rsp_valid. If the FIFO is non-empty, pop and load in the same edge and go to EXEC; otherwise go to IDLE.
- Latency: a command pushed into an empty, idle block at edge N is popped at N+1. rsp_valid is high after edge N+2. Sustained throughput is one result per 2 cycles with rsp_ready held at 1.
- Error: op 0011 or 1111 with b==0 gives rsp_err=1 and rsp_data=0; acc is unchanged. All other ops give rsp_err=0, rsp_data=alu_out, and acc<=alu_out.
- rsp_cout = alu_cout when op==0000, else 0.
- use_acc reads the accumulator at pop time, so it always sees the previous command's result because execution is serial.
- alu_a/alu_b/alu_sel hold their last values between commands.
- Ordering: responses return in command order. No command is dropped or duplicated.
- Maximum in flight: DEPTH in the FIFO plus 1 in EXEC/RESP.

Decomposition:
- Package alu_pkg contains:
  - opcode constants OP_ADD=0000, OP_SUB, OP_MUL, OP_DIV=0011, OP_SHL, OP_SHR, OP_LAND, OP_LOR, OP_AND, OP_OR, OP_XOR, OP_EQ, OP_NE, OP_GT, OP_LT, OP_MOD=1111;
  - state encodings S_IDLE, S_EXEC, S_RESP;
  - WIDTH=8.
- Sub-module alu_cmd_fifo: synchronous FIFO with DEPTH entries and a 21-bit entry, ports push/pop/full/empty, async active-low reset.
- The bench instantiates alu_cmd_sequencer wired to the existing ALU.

Test Plan:
- Add: op=0000, a=0x0A, b=0x02, rsp_ready=1, pushed at edge N -> rsp_valid after edge N+2; rsp_data=0x0C, rsp_cout=0, rsp_err=0, acc_out=0x0C.
- Carry: op=0000, a=0xF6, b=0x0A -> rsp_data=0x00, rsp_cout=1. Then op=0001 with the same operands -> rsp_data=0xEC, rsp_cout=0.
- Divide by zero: acc=0x0C; op=0011, a=0x0A, b=0x00 -> rsp_err=1, rsp_data=0x00, acc_out stays 0x0C. Then op=1111, a=0x0A, b=0x03 -> rsp_data=0x01, rsp_err=0.
- Accumulator chain: add 0x05+0x03 -> 0x08; then use_acc=1, op=0010, b=0x04 -> 0x20; then use_acc=1, op=0101, b=0x02 -> 0x08.
- Backpressure: rsp_ready=0, push 6 back-to-back commands -> exactly 5 accepted, then cmd_ready=0. Release rsp_ready=1 -> 5 responses in push order, one per 2 cycles; rsp_* stable while stalled.
- Reset mid-run: assert rst_n=0 while in EXEC with 3 queued -> all outputs 0 immediately (async), no responses after release. A new add 0x01+0x01 -> 0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// the command record that travels through the command FIFO.
package alu_pkg;

  localparam int WIDTH = 8;
  localparam int OP_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SHL  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SHR  = 4'b0101;
  localparam logic [OP_W-1:0] OP_LAND = 4'b0110;
  localparam logic [OP_W-1:0] OP_LOR  = 4'b0111;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1001;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b1010;
  localparam logic [OP_W-1:0] OP_EQ   = 4'b1011;
  localparam logic [OP_W-1:0] OP_NE   = 4'b1100;
  localparam logic [OP_W-1:0] OP_GT   = 4'b1101;
  localparam logic [OP_W-1:0] OP_LT   = 4'b1110;
  localparam logic [OP_W-1:0] OP_MOD  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // 21-bit FIFO entry: {op, a, b, use_acc}
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             use_acc;
  } cmd_t;

  // Division and modulo by zero are reported as errors instead of results.
  function automatic logic is_div_by_zero(input logic [OP_W-1:0] op,
                                          input logic [WIDTH-1:0] b);
    return ((op == OP_DIV) || (op == OP_MOD)) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; one extra pointer bit distinguishes full from empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  cmd_t        mem_q [DEPTH];
  logic        do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its inputs from before the edge, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is left unreset; emptying the pointers already hides stale
  // entries, and a reset here would cost a reset net on every storage bit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the 8-bit ALU: queues commands, drives registered ALU
// operands, captures the result one cycle later and returns it as a response.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic [OP_W-1:0]  rsp_op,
  output logic [WIDTH-1:0] acc_out,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]  alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_err_q, rsp_err_d;
  logic [OP_W-1:0]  rsp_op_q, rsp_op_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic div_err;
  cmd_t push_cmd, head_cmd;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;
  assign push_cmd  = '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (push_cmd),
    .pop   (fifo_pop),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The registered ALU inputs still describe the command being executed.
  assign div_err = is_div_by_zero(alu_sel_q, alu_b_q);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_err_d   = rsp_err_q;
    rsp_op_d    = rsp_op_q;
    acc_d       = acc_q;
    fifo_pop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_op_d    = alu_sel_q;
        rsp_err_d   = div_err;
        rsp_data_d  = div_err ? '0 : alu_out;
        rsp_cout_d  = (alu_sel_q == OP_ADD) && alu_cout;
        if (!div_err) acc_d = alu_out;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // acc_q already holds the previous result here, since execution is serial.
    if (fifo_pop) begin
      alu_sel_d = head_cmd.op;
      alu_b_d   = head_cmd.b;
      alu_a_d   = head_cmd.use_acc ? acc_q : head_cmd.a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_op_q    <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_err_q   <= rsp_err_d;
      rsp_op_q    <= rsp_op_d;
      acc_q       <= acc_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_op    = rsp_op_q;
  assign acc_out   = acc_q;
  assign busy      = !fifo_empty || (state_q != S_IDLE);

endmodule
